// File: rtl/rifl_decode.sv
// RIFL RX lane decoder: strips meta, rebuilds tkeep/tlast, buffers words in a small FIFO.
// Define RIFL_DECODE_STATS_EN to add packet/word/drop statistics counters.
module rifl_decode #(
   parameter int PAYLOAD_WIDTH = 240,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [PAYLOAD_WIDTH+1:0]       rifl_rx_payload,
   input  logic                           rifl_rx_valid,
   output logic [PAYLOAD_WIDTH-1:0]       rx_lane_tdata,
   output logic [PAYLOAD_WIDTH/8-1:0]     rx_lane_tkeep,
   output logic                           rx_lane_tlast,
   output logic                           rx_lane_tvalid,
   input  logic                           rx_lane_tready,
   output logic                           rx_overflow,
   output logic                           rx_frame_err,
   input  logic                           rx_err_clr
`ifdef RIFL_DECODE_STATS_EN
   ,
   output logic [31:0]                    rx_pkt_cnt,
   output logic [31:0]                    rx_word_cnt,
   output logic [15:0]                    rx_drop_cnt
`endif
);
   localparam int NB = PAYLOAD_WIDTH / 8;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [8:0]  NB_L    = 9'(NB);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

   logic [PAYLOAD_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
   logic [NB-1:0]            r_mem_keep [FIFO_DEPTH];
   logic                     r_mem_last [FIFO_DEPTH];
   logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
   logic [AW:0]              r_count;
   logic                     r_tvalid, r_overflow, r_frame_err;
   state_t                   r_state;

   logic [1:0]               w_meta;
   logic [PAYLOAD_WIDTH-1:0] w_data, w_dat_out;
   logic [7:0]               w_cnt;
   logic [NB-1:0]            w_keep;
   logic                     w_last, w_wr, w_ferr, w_full, w_rd, w_push, w_ovf;
   logic [AW:0]              w_count_nxt;

   // Decode the meta field into a candidate FIFO word or a frame error
   always_comb begin
      w_meta    = rifl_rx_payload[PAYLOAD_WIDTH+1:PAYLOAD_WIDTH];
      w_data    = rifl_rx_payload[PAYLOAD_WIDTH-1:0];
      w_cnt     = w_data[7:0];
      w_dat_out = w_data;
      w_keep    = {NB{1'b1}};
      w_last    = 1'b0;
      w_wr      = 1'b0;
      w_ferr    = 1'b0;
      case (w_meta)
         2'b01: w_wr = rifl_rx_valid;
         2'b11: begin
            w_wr   = rifl_rx_valid;
            w_last = 1'b1;
         end
         2'b10: begin
            w_last = 1'b1;
            // byte 0 carries the valid-byte count; valid bytes are packed at the top
            if ((w_cnt != 8'd0) && ({1'b0, w_cnt} < NB_L)) begin
               w_wr      = rifl_rx_valid;
               w_keep    = ~({NB{1'b1}} >> w_cnt);
               w_dat_out = {w_data[PAYLOAD_WIDTH-1:8], 8'd0};
            end else begin
               w_ferr = rifl_rx_valid;
            end
         end
         default: w_wr = 1'b0;
      endcase
   end

   // FIFO handshake: a read in the same cycle frees room for a write into a full FIFO
   always_comb begin
      w_full = (r_count == DEPTH_L);
      w_rd   = r_tvalid & rx_lane_tready;
      w_push = w_wr & (~w_full | w_rd);
      w_ovf  = w_wr & w_full & ~w_rd;
      if (w_push && !w_rd) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_rd && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end else begin
         w_count_nxt = r_count;
      end
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_keep[i] <= '0;
            r_mem_last[i] <= 1'b0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_tvalid <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_dat_out;
            r_mem_keep[r_wr_ptr] <= w_keep;
            r_mem_last[r_wr_ptr] <= w_last;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count  <= w_count_nxt;
         r_tvalid <= (w_count_nxt != '0);
      end
   end

   // Sticky error flags; a new event wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_overflow  <= w_ovf  | (r_overflow  & ~rx_err_clr);
         r_frame_err <= w_ferr | (r_frame_err & ~rx_err_clr);
      end
   end

   // Packet boundary tracker; any dropped word resynchronises to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (w_ferr || (w_wr && !w_push)) begin
         r_state <= ST_IDLE;
      end else if (w_push) begin
         case (r_state)
            ST_IDLE:   r_state <= w_last ? ST_IDLE : ST_IN_PKT;
            ST_IN_PKT: r_state <= w_last ? ST_IDLE : ST_IN_PKT;
            default:   r_state <= ST_IDLE;
         endcase
      end else begin
         r_state <= r_state;
      end
   end

   assign rx_lane_tdata  = r_mem_data[r_rd_ptr];
   assign rx_lane_tkeep  = r_mem_keep[r_rd_ptr];
   assign rx_lane_tlast  = r_mem_last[r_rd_ptr];
   assign rx_lane_tvalid = r_tvalid;
   assign rx_overflow    = r_overflow;
   assign rx_frame_err   = r_frame_err;

`ifdef RIFL_DECODE_STATS_EN
   logic [31:0] r_pkt_cnt, r_word_cnt;
   logic [15:0] r_drop_cnt;

   // Saturating statistics counters, cleared together with the sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_cnt  <= 32'd0;
         r_word_cnt <= 32'd0;
         r_drop_cnt <= 16'd0;
      end else if (rx_err_clr) begin
         r_pkt_cnt  <= 32'd0;
         r_word_cnt <= 32'd0;
         r_drop_cnt <= 16'd0;
      end else begin
         if (w_push && w_last && (r_pkt_cnt != 32'hFFFF_FFFF)) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
         if (w_push && (r_word_cnt != 32'hFFFF_FFFF)) begin
            r_word_cnt <= r_word_cnt + 32'd1;
         end
         if ((w_ferr || w_ovf) && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

   assign rx_pkt_cnt  = r_pkt_cnt;
   assign rx_word_cnt = r_word_cnt;
   assign rx_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_rifl_decode.sv
// Randomised self-checking bench for rifl_decode against a queue-based reference model.
module tb_rifl_decode;
   localparam int PW = 240;
   localparam int NB = 30;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [PW+1:0]   payload = '0;
   logic            valid = 1'b0;
   logic [PW-1:0]   tdata;
   logic [NB-1:0]   tkeep;
   logic            tlast, tvalid, overflow, frame_err;
   logic            tready = 1'b1;
   logic            err_clr = 1'b0;
`ifdef RIFL_DECODE_STATS_EN
   logic [31:0]     pkt_cnt, word_cnt;
   logic [15:0]     drop_cnt;
   int              m_pkt, m_word, m_drop;
`endif

   int total = 0;
   int bad   = 0;

   logic [PW-1:0] q_data[$];
   logic [NB-1:0] q_keep[$];
   logic          q_last[$];
   logic          m_ovf = 1'b0;
   logic          m_ferr = 1'b0;

   rifl_decode #(.PAYLOAD_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .rifl_rx_payload(payload), .rifl_rx_valid(valid),
      .rx_lane_tdata(tdata), .rx_lane_tkeep(tkeep), .rx_lane_tlast(tlast),
      .rx_lane_tvalid(tvalid), .rx_lane_tready(tready),
      .rx_overflow(overflow), .rx_frame_err(frame_err), .rx_err_clr(err_clr)
`ifdef RIFL_DECODE_STATS_EN
      , .rx_pkt_cnt(pkt_cnt), .rx_word_cnt(word_cnt), .rx_drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] rand_data();
      logic [PW-1:0] r = '0;
      for (int i = 0; i < PW / 32; i++) r = {r[PW-33:0], 32'($urandom)};
      r = {r[PW-17:0], 16'($urandom)};
      return r;
   endfunction

   function automatic void model_clear();
      q_data.delete(); q_keep.delete(); q_last.delete();
      m_ovf = 1'b0; m_ferr = 1'b0;
`ifdef RIFL_DECODE_STATS_EN
      m_pkt = 0; m_word = 0; m_drop = 0;
`endif
   endfunction

   // Reference behaviour for one clock edge, derived from the frame rules
   function automatic void model_edge();
      logic [1:0]    meta = payload[PW+1:PW];
      logic [PW-1:0] d = payload[PW-1:0];
      int            cnt = int'(payload[7:0]);
      logic [NB-1:0] k = '1;
      logic          l = 1'b0, wr = 1'b0, fe = 1'b0, ov = 1'b0, pushed = 1'b0;
      if (valid) begin
         if (meta == 2'b01) wr = 1'b1;
         else if (meta == 2'b11) begin wr = 1'b1; l = 1'b1; end
         else if (meta == 2'b10) begin
            if (cnt >= 1 && cnt <= NB - 1) begin
               wr = 1'b1; l = 1'b1; d[7:0] = 8'h00;
               for (int b = 0; b < NB; b++) k[b] = (b >= NB - cnt);
            end else fe = 1'b1;
         end
      end
      if (q_data.size() > 0 && tready) begin
         void'(q_data.pop_front()); void'(q_keep.pop_front()); void'(q_last.pop_front());
      end
      if (wr) begin
         if (q_data.size() < DEPTH) begin
            q_data.push_back(d); q_keep.push_back(k); q_last.push_back(l); pushed = 1'b1;
         end else ov = 1'b1;
      end
      m_ovf  = ov | (m_ovf & !err_clr);
      m_ferr = fe | (m_ferr & !err_clr);
`ifdef RIFL_DECODE_STATS_EN
      if (err_clr) begin m_pkt = 0; m_word = 0; m_drop = 0; end
      else begin
         m_pkt  += (pushed && l) ? 1 : 0;
         m_word += pushed ? 1 : 0;
         m_drop += (fe || ov) ? 1 : 0;
      end
`endif
   endfunction

   task automatic check_outputs();
      chk("tvalid", 256'(tvalid), 256'(q_data.size() > 0));
      if (q_data.size() > 0) begin
         chk("tdata", 256'(tdata), 256'(q_data[0]));
         chk("tkeep", 256'(tkeep), 256'(q_keep[0]));
         chk("tlast", 256'(tlast), 256'(q_last[0]));
      end
      chk("overflow", 256'(overflow), 256'(m_ovf));
      chk("frame_err", 256'(frame_err), 256'(m_ferr));
`ifdef RIFL_DECODE_STATS_EN
      chk("pkt_cnt", 256'(pkt_cnt), 256'(m_pkt));
      chk("word_cnt", 256'(word_cnt), 256'(m_word));
      chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send(input logic [1:0] meta, input logic [7:0] low);
      logic [PW-1:0] d = rand_data();
      d[7:0]  = low;
      payload = {meta, d};
      valid   = 1'b1;
      step();
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("rst_tvalid_async", 256'(tvalid), 256'(0));
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk("rst_tvalid", 256'(tvalid), 256'(0));
         chk("rst_tdata", 256'(tdata), 256'(0));
         chk("rst_flags", 256'({overflow, frame_err}), 256'(0));
      end
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset held while a valid data word is presented
      payload = {2'b01, rand_data()};
      valid   = 1'b1;
      do_reset(3);
      step();
      chk("first_word_latency", 256'(tvalid), 256'(1));
      idle(3);

      // Three-beat packet
      send(2'b01, 8'h11); send(2'b01, 8'h22); send(2'b11, 8'h33);
      idle(4);

      // Partial EOP with five valid bytes
      send(2'b10, 8'd5);
      chk("keep5", 256'(tkeep), 256'(30'h3E00_0000));
      chk("low_byte5", 256'(tdata[7:0]), 256'(0));
      idle(3);

      // Illegal counts, then clear
      send(2'b10, 8'd0); send(2'b10, 8'd30);
      chk("ferr_set", 256'(frame_err), 256'(1));
      err_clr = 1'b1; idle(1); err_clr = 1'b0;
      chk("ferr_clr", 256'(frame_err), 256'(0));
      idle(2);

      // Overflow with stalled sink, then drain
      tready = 1'b0;
      for (int i = 0; i < 6; i++) send(2'b01, 8'(i));
      idle(3);
      chk("ovf_set", 256'(overflow), 256'(1));
      tready = 1'b1;
      idle(6);
      err_clr = 1'b1; idle(1); err_clr = 1'b0;

      // Full FIFO with simultaneous read and write
      tready = 1'b0;
      for (int i = 0; i < 4; i++) send(2'b01, 8'(i));
      tready = 1'b1;
      send(2'b01, 8'hA5); send(2'b11, 8'h5A);
      chk("no_ovf_rw", 256'(overflow), 256'(0));
      idle(8);

      // Random traffic with occasional resets mid-stream
      for (int n = 0; n < 3000; n++) begin
         logic [7:0] low;
         logic [1:0] meta = 2'($urandom);
         tready  = ($urandom_range(99, 0) < 60);
         err_clr = ($urandom_range(99, 0) < 3);
         low = 8'($urandom);
         if (meta == 2'b10 && $urandom_range(3, 0) != 0) low = 8'($urandom_range(NB - 1, 1));
         if ($urandom_range(999, 0) < 4) begin
            payload = {2'b01, rand_data()};
            valid   = 1'b1;
            do_reset(2);
            step();
         end else if ($urandom_range(3, 0) == 0) begin
            valid = 1'b0;
            step();
         end else begin
            send(meta, low);
         end
      end
      err_clr = 1'b0;
      tready  = 1'b1;
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
